// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU fetch path.
// Contents: address/data widths, the control-flow opcodes recognised by the
// fetch unit, the fetch FSM state encoding and the PC-action struct that the
// decode helper hands back to the FSM.
package cpu16_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_JZ  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    // Where the FSM goes after DECODE.
    typedef enum logic [1:0] {
        NC_FETCH = 2'd0,
        NC_ISSUE = 2'd1,
        NC_HALT  = 2'd2
    } next_class_t;

    // Which address drives pc_address on a load.
    typedef enum logic {
        SEL_IR       = 1'b0,
        SEL_REDIRECT = 1'b1
    } target_sel_t;

    typedef struct packed {
        logic        load;
        logic        inc;
        target_sel_t sel;
        next_class_t next;
    } pc_action_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of every non-clock/reset signal of the fetch unit.
//   PC side      : pc_in, pc_load, pc_inc, pc_address
//   memory side  : mem_req, mem_addr, mem_ack, mem_rdata
//   control      : run, zero_flag, redirect, redirect_addr, halted
//   downstream   : ir_valid, ir_data, ir_ready
//   debug        : state (current FSM state)
// master = the fetch unit, slave = its surroundings.
// Downstream handshake: a word transfers on a cycle with ir_valid && ir_ready;
// once raised, ir_valid and ir_data hold until that transfer, except that a
// redirect in ISSUE withdraws ir_valid on the following cycle (flush).
// Memory handshake: mem_req stays high with a stable mem_addr until mem_ack,
// which may arrive in the same cycle as the first request.
interface instruction_fetch_unit_if;
    import cpu16_pkg::*;

    logic              run;
    logic [ADDR_W-1:0] pc_in;
    logic              pc_load;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc_address;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              zero_flag;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic              ir_valid;
    logic [DATA_W-1:0] ir_data;
    logic              ir_ready;
    logic              halted;
    state_t            state;

    modport master (
        input  run, pc_in, mem_ack, mem_rdata, zero_flag, redirect,
               redirect_addr, ir_ready,
        output pc_load, pc_inc, pc_address, mem_req, mem_addr, ir_valid,
               ir_data, halted, state
    );

    modport slave (
        output run, pc_in, mem_ack, mem_rdata, zero_flag, redirect,
               redirect_addr, ir_ready,
        input  pc_load, pc_inc, pc_address, mem_req, mem_addr, ir_valid,
               ir_data, halted, state
    );

endinterface

// File: rtl/pc_action_decode.sv
// Combinational PC-action decode for the DECODE state.
// Inputs : opcode (top nibble of the instruction register), zero_flag, redirect
// Output : action = {load, inc, target select, next-state class}
// A redirect overrides whatever the opcode would have done.
module pc_action_decode
    import cpu16_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       zero_flag,
    input  logic       redirect,
    output pc_action_t action
);

    always_comb begin
        action = '{load: 1'b0, inc: 1'b0, sel: SEL_IR, next: NC_FETCH};
        if (redirect) begin
            action.load = 1'b1;
            action.sel  = SEL_REDIRECT;
        end else begin
            case (opcode)
                OP_JMP: action.load = 1'b1;
                OP_JZ: begin
                    action.load = zero_flag;
                    action.inc  = ~zero_flag;
                end
                OP_HLT: action.next = NC_HALT;
                default: begin
                    action.inc  = 1'b1;
                    action.next = NC_ISSUE;
                end
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: reads pc_in, fetches the word through the req/ack port,
// resolves JMP/JZ/HLT, pulses exactly one of pc_inc/pc_load per instruction
// and hands ordinary instructions downstream on the valid/ready port.
// Ports: clk, rst (async, active high), bus (instruction_fetch_unit_if.master).
module instruction_fetch_unit
    import cpu16_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    instruction_fetch_unit_if.master  bus
);

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] ir_q;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    pc_action_t        dec_act;

    // A fetch that was overtaken by a redirect (earlier, or in the ack cycle)
    // has its data dropped; the newest redirect target wins.
    logic              discard;
    logic [ADDR_W-1:0] fetch_target;

    assign discard      = pend_valid | bus.redirect;
    assign fetch_target = bus.redirect ? bus.redirect_addr : pend_addr;

    pc_action_decode u_pc_action_decode (
        .opcode    (ir_q[DATA_W-1 -: 4]),
        .zero_flag (bus.zero_flag),
        .redirect  (bus.redirect),
        .action    (dec_act)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The PC cannot move during FETCH, so a redirect there is parked until
    // the outstanding request completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q       <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
        end else if (state == S_FETCH) begin
            if (bus.mem_ack) begin
                pend_valid <= 1'b0;
                if (!discard) begin
                    ir_q <= bus.mem_rdata;
                end
            end else if (bus.redirect) begin
                pend_valid <= 1'b1;
                pend_addr  <= bus.redirect_addr;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (!bus.redirect && bus.run) next_state = S_FETCH;
            S_FETCH:  if (bus.mem_ack && !discard) next_state = S_DECODE;
            S_DECODE: begin
                case (dec_act.next)
                    NC_ISSUE: next_state = S_ISSUE;
                    NC_HALT:  next_state = S_HALT;
                    default:  next_state = S_FETCH;
                endcase
            end
            S_ISSUE:  if (bus.redirect || bus.ir_ready) next_state = S_FETCH;
            S_HALT:   if (!bus.redirect && bus.run) next_state = S_FETCH;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.pc_load    = 1'b0;
        bus.pc_inc     = 1'b0;
        bus.pc_address = '0;
        bus.mem_req    = 1'b0;
        bus.mem_addr   = '0;
        bus.ir_valid   = 1'b0;
        bus.halted     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.redirect) begin
                    bus.pc_load    = 1'b1;
                    bus.pc_address = bus.redirect_addr;
                end
            end
            S_FETCH: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = bus.pc_in;
                if (bus.mem_ack && discard) begin
                    bus.pc_load    = 1'b1;
                    bus.pc_address = fetch_target;
                end
            end
            S_DECODE: begin
                bus.pc_load = dec_act.load;
                bus.pc_inc  = dec_act.inc;
                if (dec_act.load) begin
                    bus.pc_address = (dec_act.sel == SEL_REDIRECT) ?
                                     bus.redirect_addr : ir_q[ADDR_W-1:0];
                end
            end
            S_ISSUE: begin
                bus.ir_valid = 1'b1;
                if (bus.redirect) begin
                    bus.pc_load    = 1'b1;
                    bus.pc_address = bus.redirect_addr;
                end
            end
            S_HALT: begin
                bus.halted = 1'b1;
                if (bus.redirect) begin
                    bus.pc_load    = 1'b1;
                    bus.pc_address = bus.redirect_addr;
                end else if (bus.run) begin
                    bus.pc_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.ir_data = ir_q;
    assign bus.state   = state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
    import cpu16_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Program counter that the unit drives.
    logic [11:0] pc;
    always @(posedge clk or posedge rst) begin
        if (rst)              pc <= 12'h000;
        else if (bus.pc_load) pc <= bus.pc_address;
        else if (bus.pc_inc)  pc <= pc + 12'h001;
    end
    assign bus.pc_in = pc;

    logic [15:0] mem [0:4095];
    int          checks   = 0;
    int          failures = 0;

    // memory / downstream behaviour knobs
    int   wait_cfg   = 0;
    bit   rand_waits = 1'b0;
    bit   rand_ready = 1'b0;
    bit   mem_active = 1'b0;
    int   wcnt       = 0;
    bit   mon_en     = 1'b0;
    bit   prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0;

    logic [11:0] addr_q [$];
    logic [15:0] exp_q  [$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the memory and ready side for this cycle, let it settle, then
    // run the always-on monitors.
    task automatic settle();
        if (bus.mem_req) begin
            if (!mem_active) begin
                mem_active = 1'b1;
                wcnt = rand_waits ? int'($urandom_range(0, 2)) : wait_cfg;
            end
            if (wcnt == 0) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr];
                mem_active    = 1'b0;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 16'($urandom);
                wcnt--;
            end
        end else begin
            bus.mem_ack = 1'b0;
            mem_active  = 1'b0;
        end
        if (rand_ready) bus.ir_ready = 1'($urandom_range(0, 1));
        #1;
        if (bus.pc_load && bus.pc_inc) check("pulse_excl", 16'h1, 16'h0);
        if (prev_stall) begin
            check("stall_valid", 16'(bus.ir_valid), 16'h1);
            check("stall_data", bus.ir_data, prev_data);
        end
        prev_stall = bus.ir_valid && !bus.ir_ready && !bus.redirect;
        prev_data  = bus.ir_data;
        if (mon_en && bus.mem_req && bus.mem_ack && addr_q.size() > 0)
            check("rand_fetch_addr", 16'(bus.mem_addr), 16'(addr_q.pop_front()));
        if (mon_en && bus.ir_valid && bus.ir_ready && exp_q.size() > 0)
            check("rand_issue_data", bus.ir_data, exp_q.pop_front());
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        bus.run           = 1'b0;
        bus.mem_ack       = 1'b0;
        bus.mem_rdata     = 16'h0;
        bus.zero_flag     = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = 12'h0;
        bus.ir_ready      = 1'b1;
        mem_active        = 1'b0;
        prev_stall        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
    endtask

    // Instruction-level view of the program: the sequence of fetch addresses
    // and of words handed downstream, with a fixed zero flag.
    task automatic build_model(input logic [11:0] start, input bit z, input int n);
        logic [11:0] p;
        logic [15:0] w;
        p = start;
        addr_q.delete();
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            addr_q.push_back(p);
            w = mem[p];
            if (w[15:12] == OP_JMP)                p = w[11:0];
            else if (w[15:12] == OP_JZ && z)       p = w[11:0];
            else if (w[15:12] == OP_JZ)            p = p + 12'h001;
            else begin
                exp_q.push_back(w);
                p = p + 12'h001;
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;
        mem[12'h000] = 16'h1234;
        mem[12'h001] = 16'hC0F0;
        mem[12'h0F0] = 16'hD055;
        mem[12'h055] = 16'hD055;
        mem[12'h056] = 16'hABCD;
        mem[12'h057] = 16'h1111;
        mem[12'h200] = 16'hF000;
        mem[12'h201] = 16'h0042;

        do_reset();
        check("rst_state", 16'(bus.state), 16'(S_IDLE));
        check("rst_mem_req", 16'(bus.mem_req), 16'h0);
        check("rst_pc_load", 16'(bus.pc_load), 16'h0);
        check("rst_pc_inc", 16'(bus.pc_inc), 16'h0);
        check("rst_ir_valid", 16'(bus.ir_valid), 16'h0);
        check("rst_ir_data", bus.ir_data, 16'h0);
        check("rst_halted", 16'(bus.halted), 16'h0);

        // sequential instruction
        bus.run = 1'b1; settle();
        check("idle_no_req", 16'(bus.mem_req), 16'h0);
        step(); bus.run = 1'b0; settle();
        check("f0_req", 16'(bus.mem_req), 16'h1);
        check("f0_addr", 16'(bus.mem_addr), 16'h000);
        step(); settle();
        check("d0_inc", 16'(bus.pc_inc), 16'h1);
        check("d0_load", 16'(bus.pc_load), 16'h0);
        step(); settle();
        check("i0_valid", 16'(bus.ir_valid), 16'h1);
        check("i0_data", bus.ir_data, 16'h1234);
        step(); settle();
        check("f1_addr", 16'(bus.mem_addr), 16'h001);

        // JMP
        step(); settle();
        check("jmp_load", 16'(bus.pc_load), 16'h1);
        check("jmp_addr", 16'(bus.pc_address), 16'h0F0);
        check("jmp_inc", 16'(bus.pc_inc), 16'h0);
        step(); settle();
        check("jmp_no_valid", 16'(bus.ir_valid), 16'h0);
        check("jmp_fetch", 16'(bus.mem_addr), 16'h0F0);

        // JZ taken, then not taken
        step(); bus.zero_flag = 1'b1; settle();
        check("jz1_load", 16'(bus.pc_load), 16'h1);
        check("jz1_addr", 16'(bus.pc_address), 16'h055);
        step(); bus.zero_flag = 1'b0; settle();
        check("jz1_fetch", 16'(bus.mem_addr), 16'h055);
        step(); settle();
        check("jz0_inc", 16'(bus.pc_inc), 16'h1);
        check("jz0_load", 16'(bus.pc_load), 16'h0);
        step(); settle();
        check("jz0_fetch", 16'(bus.mem_addr), 16'h056);

        // downstream stall for 4 cycles
        step(); bus.ir_ready = 1'b0; settle();
        for (int i = 0; i < 4; i++) begin
            step(); settle();
            check("stall_v", 16'(bus.ir_valid), 16'h1);
            check("stall_d", bus.ir_data, 16'hABCD);
            check("stall_noreq", 16'(bus.mem_req), 16'h0);
        end
        step(); bus.ir_ready = 1'b1; settle();
        check("stall_hs", 16'(bus.ir_valid), 16'h1);

        // redirect during a slow fetch
        step(); wait_cfg = 3; bus.redirect = 1'b1; bus.redirect_addr = 12'h200; settle();
        check("rd_req0", 16'(bus.mem_req), 16'h1);
        check("rd_noload", 16'(bus.pc_load), 16'h0);
        step(); bus.redirect = 1'b0; settle();
        check("rd_req1", 16'(bus.mem_req), 16'h1);
        step(); settle();
        check("rd_req2", 16'(bus.mem_req), 16'h1);
        step(); wait_cfg = 0; settle();
        check("rd_ack_load", 16'(bus.pc_load), 16'h1);
        check("rd_ack_addr", 16'(bus.pc_address), 16'h200);
        check("rd_ack_inc", 16'(bus.pc_inc), 16'h0);
        step(); settle();
        check("rd_refetch", 16'(bus.mem_addr), 16'h200);
        check("rd_still_fetch", 16'(bus.state), 16'(S_FETCH));

        // HLT and resume
        step(); settle();
        check("hlt_noload", 16'(bus.pc_load), 16'h0);
        check("hlt_noinc", 16'(bus.pc_inc), 16'h0);
        step(); settle();
        check("hlt_halted", 16'(bus.halted), 16'h1);
        check("hlt_pc", 16'(pc), 16'h200);
        step(); bus.run = 1'b1; settle();
        check("hlt_run_inc", 16'(bus.pc_inc), 16'h1);
        step(); bus.run = 1'b0; wait_cfg = 3; settle();
        check("hlt_resume_addr", 16'(bus.mem_addr), 16'h201);
        check("hlt_resume_req", 16'(bus.mem_req), 16'h1);

        // reset in the middle of a fetch
        rst = 1'b1;
        #1;
        check("rstmid_req", 16'(bus.mem_req), 16'h0);
        check("rstmid_state", 16'(bus.state), 16'(S_IDLE));
        wait_cfg = 0;

        // randomized programs against the instruction-level model
        for (int seg = 0; seg < 3; seg++) begin
            int budget;
            do_reset();
            for (int a = 0; a < 4096; a++) begin
                int r;
                logic [15:0] w;
                r = int'($urandom_range(0, 9));
                w = 16'($urandom);
                if (r < 2)      w[15:12] = OP_JMP;
                else if (r < 4) w[15:12] = OP_JZ;
                else            w[15:12] = 4'($urandom_range(0, 11));
                mem[a] = w;
            end
            bus.zero_flag = seg[0];
            build_model(12'h000, seg[0], 40);
            mon_en     = 1'b1;
            rand_waits = 1'b1;
            bus.run    = 1'b1; settle();
            step(); bus.run = 1'b0; rand_ready = 1'b1; settle();
            budget = 2000;
            while ((addr_q.size() > 0 || exp_q.size() > 0) && budget > 0) begin
                step(); settle();
                budget--;
            end
            check("rand_done", 16'(addr_q.size() + exp_q.size()), 16'h0);
            mon_en     = 1'b0;
            rand_waits = 1'b0;
            rand_ready = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
